// File: rtl/mult_sequencer_if.sv
// Operand stream, multipli handshake and result stream
// of mult_sequencer, grouped for port use.
interface mult_sequencer_if #(
  parameter int N = 8
);
  logic           IN_VALID;
  logic           IN_READY;
  logic [N-1:0]   IN_A;
  logic [N-1:0]   IN_B;
  logic           M_START;
  logic [N-1:0]   M_A;
  logic [N-1:0]   M_B;
  logic [2*N-1:0] M_S;
  logic           M_END;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [2*N-1:0] OUT_S;
  logic           OUT_ERR;
  logic           ERR_STICKY;
  logic [15:0]    OP_COUNT;

  modport master (
    input  IN_VALID, IN_A, IN_B,
    input  M_S, M_END, OUT_READY,
    output IN_READY, M_START, M_A, M_B,
    output OUT_VALID, OUT_S, OUT_ERR,
    output ERR_STICKY, OP_COUNT
  );

  modport slave (
    output IN_VALID, IN_A, IN_B,
    output M_S, M_END, OUT_READY,
    input  IN_READY, M_START, M_A, M_B,
    input  OUT_VALID, OUT_S, OUT_ERR,
    input  ERR_STICKY, OP_COUNT
  );
endinterface

// File: rtl/mult_sequencer.sv
// Operand FIFO, START/END sequencing and result hold
// in front of the multipli signed sequential multiplier.
module mult_sequencer #(
  parameter int N       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic CLOCK,
  input  logic RESET,
  mult_sequencer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, HOLD
  } state_t;

  state_t state, state_n;

  logic [2*N-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           full, empty;
  logic           push, pop;
  logic           m_end_q, done;
  logic [TW-1:0]  timer;
  logic           expired, fire;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = bus.IN_VALID && !full;
  assign pop   = (state == IDLE) && !empty;
  assign done    = bus.M_END && !m_end_q;
  assign expired = (timer == TMR_LAST);
  assign fire    = bus.OUT_VALID && bus.OUT_READY;

  assign bus.IN_READY = !full;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (!empty) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (done || expired) state_n = HOLD;
      HOLD:    if (fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  // Occupancy count, not pointer compare, tells full from empty.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (push) mem[wr_ptr] <= {bus.IN_A, bus.IN_B};
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      m_end_q        <= 1'b0;
      timer          <= '0;
      bus.M_START    <= 1'b0;
      bus.M_A        <= '0;
      bus.M_B        <= '0;
      bus.OUT_VALID  <= 1'b0;
      bus.OUT_S      <= '0;
      bus.OUT_ERR    <= 1'b0;
      bus.ERR_STICKY <= 1'b0;
      bus.OP_COUNT   <= '0;
    end else begin
      m_end_q     <= bus.M_END;
      bus.M_START <= pop;
      if (pop) {bus.M_A, bus.M_B} <= mem[rd_ptr];

      if (state == ISSUE)
        timer <= '0;
      else if (state == WAIT && !done && !expired)
        timer <= timer + TMR_ONE;

      // A completion in the expiry cycle still counts as success.
      if (state == WAIT && done) begin
        bus.OUT_S     <= bus.M_S;
        bus.OUT_ERR   <= 1'b0;
        bus.OUT_VALID <= 1'b1;
      end else if (state == WAIT && expired) begin
        bus.OUT_S      <= '0;
        bus.OUT_ERR    <= 1'b1;
        bus.OUT_VALID  <= 1'b1;
        bus.ERR_STICKY <= 1'b1;
      end else if (state == HOLD && fire) begin
        bus.OUT_VALID <= 1'b0;
        bus.OP_COUNT  <= bus.OP_COUNT + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: behavioural multipli model,
// result scoreboard, vector table and corner sequences.
module tb_mult_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_sequencer_if #(.N(8)) bus ();

  mult_sequencer #(
    .N(8), .DEPTH(4), .TIMEOUT(64)
  ) dut (
    .CLOCK(clk),
    .RESET(rst),
    .bus(bus)
  );

  typedef struct {
    logic        err;
    logic [15:0] s;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] s;
  } vec_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  function automatic logic [15:0] prod(input logic [7:0] a,
                                       input logic [7:0] b);
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // multipli model: 0 = pulsed END, 1 = level END, 2 = hung
  int mode = 0;
  int lat = 9;
  int cnt_m = 0;
  logic busy = 1'b0;
  logic signed [7:0] ma_l = '0;
  logic signed [7:0] mb_l = '0;

  always @(posedge clk) begin
    if (bus.M_START) begin
      ma_l  <= bus.M_A;
      mb_l  <= bus.M_B;
      busy  <= (mode != 2);
      cnt_m <= lat;
      if (mode != 1) bus.M_END <= 1'b0;
    end else if (busy) begin
      if (cnt_m <= 1) begin
        busy      <= 1'b0;
        bus.M_END <= 1'b1;
        bus.M_S   <= ma_l * mb_l;
      end else begin
        cnt_m     <= cnt_m - 1;
        bus.M_END <= 1'b0;
      end
    end else begin
      bus.M_END <= (mode == 1);
    end
  end

  // monitor
  int start_hi = 0, outs = 0;
  int start_cyc = 0, end_cyc = 0, valid_cyc = 0, acc_cyc = 0;
  logic [7:0] start_a, start_b;
  logic mend_prev = 1'b0, ov_prev = 1'b0, hold_prev = 1'b0;
  logic [15:0] s_prev;
  logic err_prev;
  exp_t e;

  always @(negedge clk) begin
    if (bus.M_START) begin
      start_hi++;
      start_cyc = cyc;
      start_a = bus.M_A;
      start_b = bus.M_B;
    end
    if (bus.M_END === 1'b1 && !mend_prev) end_cyc = cyc;
    if (bus.OUT_VALID && !ov_prev) valid_cyc = cyc;
    if (hold_prev) begin
      chk("hold_valid", 32'(bus.OUT_VALID), 32'd1);
      chk("hold_s", 32'(bus.OUT_S), 32'(s_prev));
      chk("hold_err", 32'(bus.OUT_ERR), 32'(err_prev));
    end
    if (!rst && bus.OUT_VALID && bus.OUT_READY) begin
      outs++;
      if (sb.size() == 0) begin
        chk("extra_result", 32'(bus.OUT_S), 32'hffffffff);
      end else begin
        e = sb.pop_front();
        chk("out_s", 32'(bus.OUT_S), 32'(e.s));
        chk("out_err", 32'(bus.OUT_ERR), 32'(e.err));
      end
    end
    mend_prev = (bus.M_END === 1'b1);
    ov_prev   = bus.OUT_VALID;
    hold_prev = bus.OUT_VALID && !bus.OUT_READY && !rst;
    s_prev    = bus.OUT_S;
    err_prev  = bus.OUT_ERR;
  end

  task automatic push_pair(input logic [7:0] a,
                           input logic [7:0] b,
                           input logic err,
                           input logic [15:0] s);
    int w = 0;
    @(posedge clk); #1;
    bus.IN_VALID = 1'b1;
    bus.IN_A = a;
    bus.IN_B = b;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.IN_READY && w < 300);
    if (!bus.IN_READY) begin
      chk("push_stalled", 32'(w), 32'd0);
    end else begin
      sb.push_back('{err, s});
      acc_cyc = cyc;
    end
    @(posedge clk); #1;
    bus.IN_VALID = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int w = 0;
    while ((sb.size() != 0 || bus.OUT_VALID) && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_start(input int s0);
    int w = 0;
    while (start_hi == s0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("start_seen", 32'(start_hi != s0), 32'd1);
  endtask

  vec_t tbl[5];
  int s0, o0;
  logic bp_on;
  logic [7:0] ra, rb;

  initial begin
    tbl[0] = '{8'd3,    8'd5,    16'h000F};
    tbl[1] = '{8'hF9,   8'd7,    16'hFFCF};
    tbl[2] = '{8'd127,  8'd127,  16'h3F01};
    tbl[3] = '{8'h80,   8'h80,   16'h4000};
    tbl[4] = '{8'd0,    8'hFF,   16'h0000};

    bus.IN_VALID = 1'b0;
    bus.IN_A = '0;
    bus.IN_B = '0;
    bus.OUT_READY = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.IN_READY), 32'd1);
    chk("rst_m_start", 32'(bus.M_START), 32'd0);
    chk("rst_m_ab", 32'({bus.M_A, bus.M_B}), 32'd0);
    chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("rst_out_s", 32'(bus.OUT_S), 32'd0);
    chk("rst_out_err", 32'(bus.OUT_ERR), 32'd0);
    chk("rst_sticky", 32'(bus.ERR_STICKY), 32'd0);
    chk("rst_op_count", 32'(bus.OP_COUNT), 32'd0);

    // single op, 9-cycle multiplier
    s0 = start_hi;
    push_pair(8'h78, 8'h80, 1'b0, 16'hC400);
    wait_drain(300);
    chk("start_latency", 32'(start_cyc - acc_cyc), 32'd2);
    chk("valid_latency", 32'(valid_cyc - end_cyc), 32'd1);
    chk("start_pulses", 32'(start_hi - s0), 32'd1);
    chk("start_a", 32'(start_a), 32'h78);
    chk("start_b", 32'(start_b), 32'h80);
    chk("count_single", 32'(bus.OP_COUNT), 32'd1);

    // FIFO fill under output backpressure
    lat = 3;
    @(posedge clk); #1 bus.OUT_READY = 1'b0;
    s0 = start_hi;
    for (int i = 0; i < 5; i++) begin
      push_pair(tbl[i].a, tbl[i].b, 1'b0, tbl[i].s);
      if (i == 0) wait_start(s0);
    end
    @(negedge clk);
    chk("in_ready_full", 32'(bus.IN_READY), 32'd0);
    chk("fill_one_issued", 32'(start_hi - s0), 32'd1);
    @(posedge clk); #1 bus.OUT_READY = 1'b1;
    wait_drain(500);
    chk("count_fill", 32'(bus.OP_COUNT), 32'd6);

    // level-held END, dropped one cycle after START
    mode = 1;
    lat = 4;
    s0 = start_hi;
    push_pair(8'd10, 8'hFD, 1'b0, prod(8'd10, 8'hFD));
    push_pair(8'hCE, 8'hCE, 1'b0, prod(8'hCE, 8'hCE));
    push_pair(8'd127, 8'h80, 1'b0, prod(8'd127, 8'h80));
    wait_drain(500);
    chk("level_starts", 32'(start_hi - s0), 32'd3);
    chk("count_level", 32'(bus.OP_COUNT), 32'd9);

    // hung multiplier, then recovery
    mode = 2;
    repeat (2) @(posedge clk);
    push_pair(8'd5, 8'd6, 1'b1, 16'h0000);
    wait_drain(300);
    chk("timeout_cycles", 32'(valid_cyc - start_cyc), 32'd65);
    chk("sticky_set", 32'(bus.ERR_STICKY), 32'd1);
    mode = 0;
    lat = 5;
    push_pair(8'd5, 8'd6, 1'b0, 16'd30);
    wait_drain(300);
    chk("sticky_kept", 32'(bus.ERR_STICKY), 32'd1);
    chk("count_timeout", 32'(bus.OP_COUNT), 32'd11);

    // reset while waiting with two pairs buffered
    mode = 2;
    @(posedge clk); #1 bus.OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) push_pair(8'd1, 8'd2, 1'b1, 16'h0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("mid_sticky", 32'(bus.ERR_STICKY), 32'd0);
    chk("mid_op_count", 32'(bus.OP_COUNT), 32'd0);
    chk("mid_m_ab", 32'({bus.M_A, bus.M_B}), 32'd0);
    chk("mid_out_s_err", 32'({bus.OUT_S, bus.OUT_ERR}), 32'd0);
    chk("mid_in_ready", 32'(bus.IN_READY), 32'd1);
    s0 = start_hi;
    repeat (10) @(negedge clk);
    chk("mid_no_start", 32'(start_hi - s0), 32'd0);

    // random backpressure over 20 ops
    mode = 0;
    lat = 2;
    bp_on = 1'b1;
    o0 = outs;
    fork
      begin
        while (bp_on) begin
          @(posedge clk); #1;
          bus.OUT_READY = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      push_pair(ra, rb, 1'b0, prod(ra, rb));
    end
    wait_drain(3000);
    bp_on = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.OUT_READY = 1'b1;
    @(negedge clk);
    chk("bp_outs", 32'(outs - o0), 32'd20);
    chk("bp_op_count", 32'(bus.OP_COUNT), 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
